evm_multi_ballot: RTL and testbench
===================================

Name: evm_multi_ballot

Overview:
Parametrised electronic voting machine core, successor to the fixed three-candidate EVM. Supports NUM_CAND candidates and CNT_W-bit tallies. Adds officer-issued ballots (one vote per issue), press debounce, multi-press rejection and saturating counters. After voting closes it runs a sequential winner/tie scan. Sits between the synchronised button/officer inputs and the result display logic.

Parameters:
NUM_CAND, 4, number of candidates (2..16)
CNT_W, 8, tally width per candidate
IDX_W, 2, winner index width; 2**IDX_W >= NUM_CAND
DEBOUNCE_CYC, 3, consecutive samples a single button must be high before a vote counts (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
i_ballot_issue  in  1  officer pulse; arms one ballot
i_candidate  in  NUM_CAND  candidate buttons, bit k = candidate k, level, synchronous to clk
i_voting_over  in  1  close poll (level or pulse)
o_ballot_ready  out  1  high while a ballot is armed
o_vote_ack  out  1  1-cycle pulse when a vote is recorded
o_invalid_press  out  1  1-cycle pulse on onset of a multi-button press while armed
o_overflow  out  1  sticky; set when any tally saturates
o_totals  out  NUM_CAND*CNT_W  tally k in bits [k*CNT_W +: CNT_W]
o_winner  out  IDX_W  lowest-index candidate with maximum tally
o_tie  out  1  another candidate shares the maximum
o_results_valid  out  1  winner/tie final; held until reset

Behaviour:
- Reset (async, any state): all tallies 0; every output 0; state IDLE; debounce counter 0.
- States: IDLE, ARMED, WAIT_REL, CLOSED, SCAN, DONE.
- IDLE: i_ballot_issue -> ARMED. Button presses are ignored.
- ARMED: o_ballot_ready=1.
  - Debounce counter increments on each edge where exactly one button is high and the pattern equals the previous sample. It resets to 0 on any other pattern.
  - On the edge giving DEBOUNCE_CYC consecutive identical one-hot samples: tally[k] += 1; o_vote_ack=1 for one cycle; go to WAIT_REL. The updated tally is visible in the same cycle as the ack.
  - Two or more buttons high: no vote; counter cleared; o_invalid_press pulses on the first cycle of that condition only; ballot stays armed.
  - Additional i_ballot_issue pulses are ignored; no stacking of ballots.
- WAIT_REL: o_ballot_ready=0. Return to IDLE on the first cycle with i_candidate==0. Holding a button therefore cannot cast a second vote.
- Saturation: a tally at 2**CNT_W-1 holds its value. The vote is still acked and o_overflow is set, sticky until reset.
- i_voting_over has priority over every other input in IDLE, ARMED and WAIT_REL; next state is CLOSED.
  - An armed ballot is discarded with no vote.
  - A vote acked in the same cycle still counts, since it was debounced before the edge.
- CLOSED: tallies frozen; all buttons, ballot issues and i_voting_over ignored. Next cycle -> SCAN.
- SCAN: one candidate compared per cycle, index 0..NUM_CAND-1, taking NUM_CAND cycles.
  - A strictly greater tally replaces the running max and index, and clears tie.
  - An equal tally sets tie.
- DONE: o_winner, o_tie and o_results_valid=1 are registered on entry and held until rst.
  - Latency from the i_voting_over edge to o_results_valid is NUM_CAND+2 cycles.
  - All tallies zero gives winner 0, tie 1.
- Reset asserted mid-scan or mid-press aborts immediately; all tallies are lost.

Test Plan:
1. Defaults. rst, issue, hold cand1 for 3 cycles -> ack on 3rd sample edge, tally1=1. Hold 10 more cycles -> no further votes. Release -> IDLE.
2. Issue, press cand0 for 2 cycles, release, press again for 3 cycles -> exactly one vote, tally0=1. Pulse cand2 without issue -> no change.
3. Issue, press cand0+cand3 together -> one o_invalid_press pulse, no vote, ready stays 1. Then cand3 alone for 3 cycles -> tally3=1.
4. Votes 2/3/1/3 on cand0..3, then voting_over -> results_valid after 6 cycles, winner=1, tie=1. Later issue/press have no effect.
5. CNT_W=2: cast 5 votes on cand2 -> tally2=3, five acks, o_overflow=1 from the 4th vote onward.
6. Issue and voting_over in the same window; assert rst during SCAN -> all outputs 0, state IDLE, next ballot counts from 0.

Source files
------------

// File: rtl/evm_multi_ballot.sv
// Parametrised voting machine core: officer-armed ballots, debounced single
// presses, multi-press rejection, saturating tallies and a sequential
// winner/tie scan after the poll closes.
module evm_multi_ballot #(
  parameter int unsigned NUM_CAND     = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned DEBOUNCE_CYC = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_ballot_issue,
  input  logic [NUM_CAND-1:0]       i_candidate,
  input  logic                      i_voting_over,
  output logic                      o_ballot_ready,
  output logic                      o_vote_ack,
  output logic                      o_invalid_press,
  output logic                      o_overflow,
  output logic [NUM_CAND*CNT_W-1:0] o_totals,
  output logic [IDX_W-1:0]          o_winner,
  output logic                      o_tie,
  output logic                      o_results_valid
);

  localparam int unsigned DCW = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    WAIT_REL = 3'd2,
    CLOSED   = 3'd3,
    SCAN     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t state, state_n;

  logic [NUM_CAND-1:0] sample_q;
  logic [DCW-1:0]      deb_cnt;
  logic                multi_q;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic [IDX_W-1:0]    scan_idx;
  logic [CNT_W-1:0]    run_max;
  logic [IDX_W-1:0]    run_idx;
  logic                run_tie;

  logic                onehot_c, multi_c, deb_hit_c;
  logic [DCW-1:0]      deb_next_c;
  logic [CNT_W-1:0]    cur_tally_c;
  logic                vote_c, invalid_c, ready_c;

  // Press classification and debounce counter next value
  always_comb begin
    onehot_c   = (|i_candidate) && ~|(i_candidate & (i_candidate - NUM_CAND'(1)));
    multi_c    = (|i_candidate) && !onehot_c;
    deb_next_c = '0;
    if (onehot_c) begin
      if ((i_candidate == sample_q) && (deb_cnt != '0)) deb_next_c = deb_cnt + DCW'(1);
      else                                                deb_next_c = DCW'(1);
    end
    deb_hit_c = onehot_c && (deb_next_c == DCW'(DEBOUNCE_CYC));
  end

  // Tally currently addressed by the scan
  always_comb begin
    cur_tally_c = '0;
    for (int k = 0; k < int'(NUM_CAND); k++) begin
      if (scan_idx == IDX_W'(k)) cur_tally_c = tally[k];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; poll close wins over every other input while open
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (i_voting_over) state_n = CLOSED;
                else if (i_ballot_issue) state_n = ARMED;
      ARMED:    if (i_voting_over) state_n = CLOSED;
                else if (deb_hit_c) state_n = WAIT_REL;
      WAIT_REL: if (i_voting_over) state_n = CLOSED;
                else if (i_candidate == '0) state_n = IDLE;
      CLOSED:   state_n = SCAN;
      SCAN:     if (scan_idx == IDX_W'(NUM_CAND - 1)) state_n = DONE;
      DONE:     state_n = DONE;
      default:  state_n = IDLE;
    endcase
  end

  // Output/control decode; a vote debounced on the closing edge still counts
  always_comb begin
    vote_c    = (state == ARMED) && deb_hit_c;
    invalid_c = (state == ARMED) && !i_voting_over && multi_c && !multi_q;
    ready_c   = (state_n == ARMED);
  end

  // Registered outputs, tallies, debounce history and scan datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ballot_ready  <= 1'b0;
      o_vote_ack      <= 1'b0;
      o_invalid_press <= 1'b0;
      o_overflow      <= 1'b0;
      o_winner        <= '0;
      o_tie           <= 1'b0;
      o_results_valid <= 1'b0;
      sample_q        <= '0;
      deb_cnt         <= '0;
      multi_q         <= 1'b0;
      scan_idx        <= '0;
      run_max         <= '0;
      run_idx         <= '0;
      run_tie         <= 1'b0;
      for (int k = 0; k < int'(NUM_CAND); k++) tally[k] <= '0;
    end else begin
      o_ballot_ready  <= ready_c;
      o_vote_ack      <= vote_c;
      o_invalid_press <= invalid_c;
      sample_q        <= i_candidate;
      multi_q         <= (state == ARMED) && multi_c;
      deb_cnt         <= ((state == ARMED) && (state_n == ARMED)) ? deb_next_c : '0;

      if (vote_c) begin
        for (int k = 0; k < int'(NUM_CAND); k++) begin
          if (i_candidate[k]) begin
            if (tally[k] == {CNT_W{1'b1}}) o_overflow <= 1'b1;
            else                           tally[k]   <= tally[k] + CNT_W'(1);
          end
        end
      end

      if (state == CLOSED) begin
        scan_idx <= '0;
        run_max  <= '0;
        run_idx  <= '0;
        run_tie  <= 1'b0;
      end else if (state == SCAN) begin
        scan_idx <= scan_idx + IDX_W'(1);
        if (cur_tally_c > run_max) begin
          run_max <= cur_tally_c;
          run_idx <= scan_idx;
          run_tie <= 1'b0;
        end else if (cur_tally_c == run_max) begin
          run_tie <= 1'b1;
        end
      end

      if (state == DONE) begin
        o_winner        <= run_idx;
        o_tie           <= run_tie;
        o_results_valid <= 1'b1;
      end
    end
  end

  // Flatten tallies onto the totals bus
  always_comb begin
    o_totals = '0;
    for (int k = 0; k < int'(NUM_CAND); k++) o_totals[k*CNT_W +: CNT_W] = tally[k];
  end

endmodule

// File: tb/tb_evm_multi_ballot.sv
// Self-checking bench for evm_multi_ballot: table-driven press sequences plus
// hand-written close/scan, saturation and reset-abort sequences.
module tb_evm_multi_ballot;

  localparam int unsigned NC  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned DEB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue = 1'b0;
  logic [NC-1:0] cand = '0;
  logic over = 1'b0;

  logic          ready, ack, inv, ovf, tie, valid;
  logic [NC*CW-1:0] totals;
  logic [1:0]    winner;

  logic          ready2, ack2, inv2, ovf2, tie2, valid2;
  logic [NC*2-1:0] totals2;
  logic [1:0]    winner2;

  int checks = 0;
  int failures = 0;
  int mdl [NC];

  evm_multi_ballot #(.NUM_CAND(NC), .CNT_W(CW), .IDX_W(2), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .rst(rst), .i_ballot_issue(issue), .i_candidate(cand),
    .i_voting_over(over), .o_ballot_ready(ready), .o_vote_ack(ack),
    .o_invalid_press(inv), .o_overflow(ovf), .o_totals(totals),
    .o_winner(winner), .o_tie(tie), .o_results_valid(valid)
  );

  evm_multi_ballot #(.NUM_CAND(NC), .CNT_W(2), .IDX_W(2), .DEBOUNCE_CYC(DEB)) dut2 (
    .clk(clk), .rst(rst), .i_ballot_issue(issue), .i_candidate(cand),
    .i_voting_over(over), .o_ballot_ready(ready2), .o_vote_ack(ack2),
    .o_invalid_press(inv2), .o_overflow(ovf2), .o_totals(totals2),
    .o_winner(winner2), .o_tie(tie2), .o_results_valid(valid2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          issue;
    logic [NC-1:0] cand;
    int            reps;
    logic          ready;
    logic          ack;
    logic          inv;
    logic [31:0]   totals;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(logic i, logic [NC-1:0] c, int r, logic rd, logic a, logic iv,
                              logic [31:0] t);
    vec_t v;
    v.issue = i; v.cand = c; v.reps = r; v.ready = rd; v.ack = a; v.inv = iv; v.totals = t;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_totals();
    logic [31:0] t;
    t = '0;
    for (int k = 0; k < int'(NC); k++) t[k*CW +: CW] = CW'(mdl[k]);
    return t;
  endfunction

  task automatic step(input logic i, input logic [NC-1:0] c, input logic o);
    @(negedge clk);
    issue = i; cand = c; over = o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; issue = 1'b0; cand = '0; over = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_totals", totals, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < int'(NC); k++) mdl[k] = 0;
  endtask

  // Issue a ballot and hold candidate k for DEB samples; caller releases
  task automatic cast(input int k, input logic over_last);
    step(1'b1, '0, 1'b0);
    chk($sformatf("cast%0d_ready", k), 32'(ready), 32'd1);
    for (int i = 0; i < int'(DEB); i++)
      step(1'b0, NC'(1 << k), (i == int'(DEB) - 1) ? over_last : 1'b0);
    if (mdl[k] < 255) mdl[k]++;
    chk($sformatf("cast%0d_ack", k), 32'(ack), 32'd1);
    chk($sformatf("cast%0d_totals", k), totals, model_totals());
  endtask

  initial begin
    // Single-press, debounce-restart and multi-press scenarios
    vecs[0]  = mk(1, 4'b0000, 1,  1, 0, 0, 32'h0000_0000);
    vecs[1]  = mk(0, 4'b0010, 2,  1, 0, 0, 32'h0000_0000);
    vecs[2]  = mk(0, 4'b0010, 1,  0, 1, 0, 32'h0000_0100);
    vecs[3]  = mk(0, 4'b0010, 10, 0, 0, 0, 32'h0000_0100);
    vecs[4]  = mk(0, 4'b0000, 1,  0, 0, 0, 32'h0000_0100);
    vecs[5]  = mk(1, 4'b0000, 1,  1, 0, 0, 32'h0000_0100);
    vecs[6]  = mk(0, 4'b0001, 2,  1, 0, 0, 32'h0000_0100);
    vecs[7]  = mk(0, 4'b0000, 1,  1, 0, 0, 32'h0000_0100);
    vecs[8]  = mk(0, 4'b0001, 2,  1, 0, 0, 32'h0000_0100);
    vecs[9]  = mk(0, 4'b0001, 1,  0, 1, 0, 32'h0000_0101);
    vecs[10] = mk(0, 4'b0000, 1,  0, 0, 0, 32'h0000_0101);
    vecs[11] = mk(0, 4'b0100, 3,  0, 0, 0, 32'h0000_0101);
    vecs[12] = mk(0, 4'b0000, 1,  0, 0, 0, 32'h0000_0101);
    vecs[13] = mk(1, 4'b0000, 1,  1, 0, 0, 32'h0000_0101);
    vecs[14] = mk(0, 4'b1001, 1,  1, 0, 1, 32'h0000_0101);
    vecs[15] = mk(0, 4'b1001, 1,  1, 0, 0, 32'h0000_0101);
    vecs[16] = mk(0, 4'b1000, 1,  1, 0, 0, 32'h0000_0101);
    vecs[17] = mk(1, 4'b1000, 1,  1, 0, 0, 32'h0000_0101);
    vecs[18] = mk(0, 4'b1000, 1,  0, 1, 0, 32'h0100_0101);
    vecs[19] = mk(0, 4'b0000, 1,  0, 0, 0, 32'h0100_0101);

    do_reset();

    for (int r = 0; r < 20; r++) begin
      for (int n = 0; n < vecs[r].reps; n++) begin
        step(vecs[r].issue, vecs[r].cand, 1'b0);
        chk($sformatf("row%0d_ready", r), 32'(ready), 32'(vecs[r].ready));
        chk($sformatf("row%0d_ack", r), 32'(ack), 32'(vecs[r].ack));
        chk($sformatf("row%0d_inv", r), 32'(inv), 32'(vecs[r].inv));
        chk($sformatf("row%0d_totals", r), totals, vecs[r].totals);
      end
    end

    // Votes 2/3/1/3; last vote debounced on the closing edge still counts
    do_reset();
    cast(0, 1'b0); step(0, '0, 0);
    cast(0, 1'b0); step(0, '0, 0);
    for (int i = 0; i < 3; i++) begin cast(1, 1'b0); step(0, '0, 0); end
    cast(2, 1'b0); step(0, '0, 0);
    cast(3, 1'b0); step(0, '0, 0);
    cast(3, 1'b0); step(0, '0, 0);
    cast(3, 1'b1);
    chk("close_ready", 32'(ready), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, NC'(1 << (i % 4)), 1'b0);
      chk($sformatf("lat%0d_valid", i), 32'(valid), (i == 6) ? 32'd1 : 32'd0);
    end
    chk("scan_winner", 32'(winner), 32'd1);
    chk("scan_tie", 32'(tie), 32'd1);
    chk("scan_totals", totals, 32'h0301_0302);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0100, 1'b0);
    chk("post_ready", 32'(ready), 32'd0);
    chk("post_totals", totals, 32'h0301_0302);
    chk("post_valid", 32'(valid), 32'd1);
    chk("post_winner", 32'(winner), 32'd1);

    // Saturation on the 2-bit instance
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      cast(2, 1'b0);
      chk($sformatf("sat%0d_ack2", v), 32'(ack2), 32'd1);
      chk($sformatf("sat%0d_tot2", v), 32'(totals2), 32'((v < 3 ? v : 3) << 4));
      chk($sformatf("sat%0d_ovf2", v), 32'(ovf2), (v >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("sat%0d_ovf", v), 32'(ovf), 32'd0);
      step(0, '0, 0);
    end

    // All-zero tallies close to winner 0 with a tie
    do_reset();
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
    chk("zero_valid", 32'(valid), 32'd1);
    chk("zero_winner", 32'(winner), 32'd0);
    chk("zero_tie", 32'(tie), 32'd1);

    // Issue coinciding with close discards the ballot; reset aborts the scan
    do_reset();
    cast(1, 1'b0); step(0, '0, 0);
    step(1'b1, '0, 1'b1);
    chk("disc_ready", 32'(ready), 32'd0);
    chk("disc_totals", totals, 32'h0000_0100);
    step(0, 4'b0001, 0);
    step(0, 4'b0001, 0);
    @(negedge clk);
    rst = 1'b1; issue = 1'b0; cand = '0; over = 1'b0;
    #1;
    chk("abort_totals", totals, 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < int'(NC); k++) mdl[k] = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 1'b0);
    chk("idle_ignore_totals", totals, 32'd0);
    chk("idle_ignore_ack", 32'(ack), 32'd0);
    step(0, '0, 0);
    cast(0, 1'b0);
    chk("fresh_totals", totals, 32'h0000_0001);
    for (int i = 0; i < 8; i++) step(0, '0, 0);
    chk("fresh_valid", 32'(valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
